// File: rtl/instruction_fetch_if.sv
// Fetch-stage bundle: instruction memory read port, redirect input and the
// valid/ready handoff into decode.
interface instruction_fetch_if;
  logic        fetch_en;
  logic [31:0] read_address;
  logic [31:0] Instruction_out;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_fault;

  modport master (
    input  fetch_en,
    input  Instruction_out,
    input  redirect_valid,
    input  redirect_target,
    input  if_ready,
    output read_address,
    output if_valid,
    output if_instr,
    output if_pc,
    output if_fault
  );

  modport slave (
    output fetch_en,
    output Instruction_out,
    output redirect_valid,
    output redirect_target,
    output if_ready,
    input  read_address,
    input  if_valid,
    input  if_instr,
    input  if_pc,
    input  if_fault
  );
endinterface

// File: rtl/instruction_fetch.sv
// Single-slot instruction fetch stage: pc register, combinational imem read and a
// registered output slot to decode. Define IFETCH_BOUND_CHECK_EN to flag out-of-range fetches.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_BYTES = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  instruction_fetch_if.master bus
);

  localparam logic [31:0] NOP = 32'h0000_0013;

`ifdef IFETCH_BOUND_CHECK_EN
  localparam bit BOUND_CHECK = 1'b1;
`else
  localparam bit BOUND_CHECK = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic        if_fault_q, if_fault_d;

  logic        slot_free;
  logic        load;
  logic [32:0] pc_last_byte;
  logic        out_of_bounds;
  logic        fetch_fault;
  logic [31:0] fetch_word;

  assign slot_free = !if_valid_q || bus.if_ready;

  // Widened so a pc near the top of the address space cannot wrap under the limit.
  assign pc_last_byte  = {1'b0, pc_q} + 33'd3;
  assign out_of_bounds = (pc_last_byte >= 33'(IMEM_BYTES));
  assign fetch_fault   = BOUND_CHECK && out_of_bounds;
  assign fetch_word    = fetch_fault ? NOP : bus.Instruction_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      if_valid_q <= 1'b0;
      if_instr_q <= NOP;
      if_pc_q    <= 32'h0000_0000;
      if_fault_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      if_fault_q <= if_fault_d;
    end
  end

  // A redirect empties the slot, so the next state depends only on fetch_en.
  always_comb begin
    state_d = state_q;
    if (bus.redirect_valid) begin
      state_d = bus.fetch_en ? RUN : IDLE;
    end else begin
      case (state_q)
        IDLE: if (bus.fetch_en) state_d = RUN;
        RUN: begin
          if (!bus.fetch_en && slot_free)        state_d = IDLE;
          else if (if_valid_q && !bus.if_ready)  state_d = HOLD;
        end
        HOLD: begin
          if (!bus.fetch_en && slot_free)        state_d = IDLE;
          else if (bus.if_ready)                 state_d = RUN;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    load       = (state_q != IDLE) && bus.fetch_en && slot_free;
    pc_d       = pc_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    if_fault_d = if_fault_q;
    if (bus.redirect_valid) begin
      pc_d       = bus.redirect_target & ~32'd3;
      if_valid_d = 1'b0;
      if_fault_d = 1'b0;
    end else if (load) begin
      if_instr_d = fetch_word;
      if_pc_d    = pc_q;
      if_valid_d = 1'b1;
      if_fault_d = fetch_fault;
      pc_d       = pc_q + 32'd4;
    end else if (bus.if_ready) begin
      if_valid_d = 1'b0;
    end
  end

  assign bus.read_address = pc_q;
  assign bus.if_valid     = if_valid_q;
  assign bus.if_instr     = if_instr_q;
  assign bus.if_pc        = if_pc_q;
  assign bus.if_fault     = if_fault_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed and randomized bench for instruction_fetch with a scoreboard fed by a
// transaction-level fetch model; honours IFETCH_BOUND_CHECK_EN.
module tb_instruction_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } item_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b1;

  item_t       exp_q[$];
  logic [31:0] m_pc = RST_PC;
  bit          m_active = 1'b0;
  bit          m_full = 1'b0;

  always #5 clk = ~clk;

  instruction_fetch_if ifc();

  instruction_fetch #(.RESET_PC(RST_PC), .IMEM_BYTES(64)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc)
  );

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    logic [31:0] w;
    if (a < 32'd64) begin
      case (a[5:2])
        4'd0:    w = 32'h0000_0000;
        4'd1:    w = 32'h0093_8333;
        4'd2:    w = 32'h0031_00B3;
        4'd5:    w = 32'h0081_2703;
        default: w = 32'hA000_0000 | {26'd0, a[5:0]};
      endcase
    end else begin
      w = {a[31:16] ^ 16'h5A5A, a[15:0]};
    end
    return w;
  endfunction

  assign ifc.Instruction_out = imem_word(ifc.read_address);

  function automatic logic exp_fault(input logic [31:0] a);
`ifdef IFETCH_BOUND_CHECK_EN
    return ({1'b0, a} + 33'd3) >= 33'd64;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] exp_instr(input logic [31:0] a);
    return exp_fault(a) ? NOP : imem_word(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: one-entry slot, an active flag and a pc, stepped per edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc     = RST_PC;
      m_active = 1'b0;
      m_full   = 1'b0;
      exp_q.delete();
    end else if (ifc.redirect_valid) begin
      m_pc     = ifc.redirect_target & ~32'd3;
      m_full   = 1'b0;
      m_active = ifc.fetch_en;
      exp_q.delete();
    end else begin
      bit free;
      bit ld;
      free = !m_full || ifc.if_ready;
      ld   = m_active && ifc.fetch_en && free;
      if (!m_active)                    m_active = ifc.fetch_en;
      else if (!ifc.fetch_en && free)   m_active = 1'b0;
      if (ld) begin
        exp_q.push_back('{m_pc, exp_instr(m_pc), exp_fault(m_pc)});
        m_full = 1'b1;
        m_pc   = m_pc + 32'd4;
      end else if (ifc.if_ready) begin
        m_full = 1'b0;
      end
    end
  end

  // Monitor: outputs are stable here and the inputs for the coming edge are set.
  always @(negedge clk) begin
    #1;
    if (rst_n && mon_en) begin
      chk("mon_read_address", ifc.read_address, m_pc);
      chk("mon_if_valid", 32'(ifc.if_valid), 32'(exp_q.size() != 0));
      if (ifc.if_valid && exp_q.size() != 0) begin
        item_t e;
        e = exp_q[0];
        chk("mon_if_pc", ifc.if_pc, e.pc);
        chk("mon_if_instr", ifc.if_instr, e.instr);
        chk("mon_if_fault", 32'(ifc.if_fault), 32'(e.fault));
        if (ifc.if_ready && !ifc.redirect_valid) void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic fe, input logic rdy, input logic rv, input logic [31:0] tgt);
    ifc.fetch_en        = fe;
    ifc.if_ready        = rdy;
    ifc.redirect_valid  = rv;
    ifc.redirect_target = tgt;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_if_valid"}, 32'(ifc.if_valid), 32'd0);
    chk({tag, "_if_pc"}, ifc.if_pc, 32'd0);
    chk({tag, "_if_instr"}, ifc.if_instr, NOP);
    chk({tag, "_if_fault"}, 32'(ifc.if_fault), 32'd0);
    chk({tag, "_read_address"}, ifc.read_address, RST_PC);
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    #1 rst_n = 1'b0;
    #1 chk_reset_values("reset");

    @(posedge clk); #2;
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 32'd0);

    tick();
    chk("idle_read_address", ifc.read_address, 32'd0);
    chk("idle_if_valid", 32'(ifc.if_valid), 32'd0);
    tick();
    chk("first_if_valid", 32'(ifc.if_valid), 32'd1);
    chk("first_if_pc", ifc.if_pc, 32'd0);
    chk("first_if_instr", ifc.if_instr, 32'h0000_0000);
    chk("first_read_address", ifc.read_address, 32'd4);
    tick();
    chk("second_if_pc", ifc.if_pc, 32'd4);
    chk("second_if_instr", ifc.if_instr, 32'h0093_8333);
    chk("second_read_address", ifc.read_address, 32'd8);

    ifc.if_ready = 1'b0;
    repeat (3) begin
      tick();
      chk("stall_if_valid", 32'(ifc.if_valid), 32'd1);
      chk("stall_if_pc", ifc.if_pc, 32'd4);
      chk("stall_if_instr", ifc.if_instr, 32'h0093_8333);
      chk("stall_read_address", ifc.read_address, 32'd8);
    end
    ifc.if_ready = 1'b1;
    tick();
    chk("release_if_pc", ifc.if_pc, 32'd8);
    chk("release_if_instr", ifc.if_instr, 32'h0031_00B3);
    chk("release_read_address", ifc.read_address, 32'd12);

    ifc.if_ready = 1'b0;
    tick();
    drive(1'b1, 1'b0, 1'b1, 32'h0000_0016);
    tick();
    chk("redirect_if_valid", 32'(ifc.if_valid), 32'd0);
    chk("redirect_read_address", ifc.read_address, 32'd20);
    drive(1'b1, 1'b1, 1'b0, 32'd0);
    tick();
    chk("target_if_valid", 32'(ifc.if_valid), 32'd1);
    chk("target_if_pc", ifc.if_pc, 32'd20);
    chk("target_if_instr", ifc.if_instr, 32'h0081_2703);

    drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
    tick();
    chk("wrap_redirect_read_address", ifc.read_address, 32'hFFFF_FFFC);
    drive(1'b1, 1'b1, 1'b0, 32'd0);
    tick();
    chk("wrap_if_pc", ifc.if_pc, 32'hFFFF_FFFC);
    chk("wrap_read_address", ifc.read_address, 32'd0);
    chk("wrap_if_fault", 32'(ifc.if_fault), 32'(exp_fault(32'hFFFF_FFFC)));

    drive(1'b1, 1'b1, 1'b1, 32'd60);
    tick();
    drive(1'b1, 1'b1, 1'b0, 32'd0);
    tick();
    chk("bound60_if_pc", ifc.if_pc, 32'd60);
    chk("bound60_if_fault", 32'(ifc.if_fault), 32'd0);
    chk("bound60_if_instr", ifc.if_instr, imem_word(32'd60));
    tick();
    chk("bound64_if_pc", ifc.if_pc, 32'd64);
    chk("bound64_if_fault", 32'(ifc.if_fault), 32'(exp_fault(32'd64)));
    chk("bound64_if_instr", ifc.if_instr, exp_instr(32'd64));

    ifc.if_ready = 1'b0;
    tick();
    ifc.fetch_en = 1'b0;
    repeat (2) begin
      tick();
      chk("fe_off_hold_valid", 32'(ifc.if_valid), 32'd1);
    end
    ifc.if_ready = 1'b1;
    tick();
    chk("fe_off_accept_valid", 32'(ifc.if_valid), 32'd0);
    tick();
    chk("fe_off_idle_valid", 32'(ifc.if_valid), 32'd0);
    ifc.fetch_en = 1'b1;
    repeat (3) tick();

    rst_n = 1'b0;
    #1 chk_reset_values("async_reset");
    tick();
    rst_n = 1'b1;
    tick();
    chk("restart_idle_valid", 32'(ifc.if_valid), 32'd0);
    tick();
    chk("restart_if_pc", ifc.if_pc, RST_PC);
    chk("restart_if_valid", 32'(ifc.if_valid), 32'd1);

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tgt;
      case ($urandom_range(0, 3))
        0:       tgt = $urandom_range(0, 80);
        1:       tgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        default: tgt = $urandom_range(0, 63);
      endcase
      drive(($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 15) == 0), tgt);
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        #1 chk("rand_reset_if_valid", 32'(ifc.if_valid), 32'd0);
        #1 rst_n = 1'b1;
      end
      tick();
    end

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
